// File: rtl/bist_addr_seq.sv
// BIST address sequencer: one full-coverage address sweep per accepted start,
// in one of four orderings, ascending or descending, advanced by a step handshake.
module bist_addr_seq #(
    parameter int unsigned A_ROW = 2,
    parameter int unsigned A_COL = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic                   i_up_down,
    input  logic [1:0]             i_mode,
    input  logic                   i_step,
    input  logic                   i_abort,
    output logic [A_ROW+A_COL-1:0] o_address,
    output logic                   o_valid,
    output logic                   o_last,
    output logic                   o_done,
    output logic                   o_busy
);

    localparam int unsigned A_W = A_ROW + A_COL;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e         r_state_q, w_state_d;
    logic [A_W-1:0] r_idx_q, w_idx_d;
    logic [1:0]     r_mode_q, w_mode_d;
    logic           r_dir_q, w_dir_d;
    logic           r_done_q, w_done_d;

    logic           w_terminal;
    logic [A_W-1:0] w_half;
    logic [A_ROW-1:0] w_row;
    logic [A_COL-1:0] w_col;

    // Terminal index is all-ones when ascending, zero when descending.
    assign w_terminal = r_dir_q ? (r_idx_q == {A_W{1'b1}}) : (r_idx_q == {A_W{1'b0}});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= StIdle;
            r_idx_q   <= '0;
            r_mode_q  <= 2'd0;
            r_dir_q   <= 1'b1;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_mode_q  <= w_mode_d;
            r_dir_q   <= w_dir_d;
            r_done_q  <= w_done_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_idx_d   = r_idx_q;
        w_mode_d  = r_mode_q;
        w_dir_d   = r_dir_q;
        w_done_d  = 1'b0;
        case (r_state_q)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StRun;
                    w_idx_d   = i_up_down ? {A_W{1'b0}} : {A_W{1'b1}};
                    w_mode_d  = i_mode;
                    w_dir_d   = i_up_down;
                end
            end
            StRun: begin
                if (i_abort) begin
                    w_state_d = StIdle;
                end else if (i_step) begin
                    if (w_terminal) begin
                        w_state_d = StIdle;
                        w_done_d  = 1'b1;
                    end else if (r_dir_q) begin
                        w_idx_d = r_idx_q + 1'b1;
                    end else begin
                        w_idx_d = r_idx_q - 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Address depends only on registered state, never on inputs.
    assign w_half = r_idx_q >> 1;
    assign w_row  = r_idx_q[A_ROW-1:0];
    assign w_col  = r_idx_q[A_W-1:A_ROW];

    always_comb begin
        o_address = r_idx_q;
        case (r_mode_q)
            2'd0: o_address = r_idx_q;
            2'd1: o_address = {w_row, w_col};
            2'd2: o_address = r_idx_q ^ w_half;
            2'd3: o_address = r_idx_q[0] ? ~w_half : w_half;
            default: o_address = r_idx_q;
        endcase
    end

    assign o_valid = (r_state_q == StRun);
    assign o_busy  = o_valid;
    assign o_last  = o_valid && w_terminal;
    assign o_done  = r_done_q;

endmodule

// File: tb/tb_bist_addr_seq.sv
// Directed self-checking bench for bist_addr_seq with a 2x2 row/column address.
module tb_bist_addr_seq;

    logic       clk;
    logic       reset;
    logic       i_start;
    logic       i_up_down;
    logic [1:0] i_mode;
    logic       i_step;
    logic       i_abort;
    logic [3:0] o_address;
    logic       o_valid;
    logic       o_last;
    logic       o_done;
    logic       o_busy;

    int n_checks;
    int n_errors;

    bist_addr_seq #(
        .A_ROW(2),
        .A_COL(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_start  (i_start),
        .i_up_down(i_up_down),
        .i_mode   (i_mode),
        .i_step   (i_step),
        .i_abort  (i_abort),
        .o_address(o_address),
        .o_valid  (o_valid),
        .o_last   (o_last),
        .o_done   (o_done),
        .o_busy   (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (o_address !== 4'd0 || o_valid !== 1'b0 || o_last !== 1'b0 ||
            o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: addr=%h valid=%b last=%b done=%b busy=%b required all 0",
                     o_address, o_valid, o_last, o_done, o_busy);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: valid=%b required 0", o_valid);
        end
    endtask

    // seq holds the 16 expected addresses, element 0 in the top nibble.
    task automatic test_sweep(input string name, input logic [1:0] mode, input logic up,
                              input logic [63:0] seq, input bit wiggle);
        logic [3:0] exp_addr;
        i_start   = 1'b1;
        i_mode    = mode;
        i_up_down = up;
        tick();
        i_start = 1'b0;
        i_step  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_addr = seq[60-4*i +: 4];
            n_checks++;
            if (o_address !== exp_addr || o_valid !== 1'b1 || o_busy !== 1'b1) begin
                n_errors++;
                $display("FAIL %s[%0d]: addr=%h valid=%b busy=%b required addr=%h valid=1 busy=1",
                         name, i, o_address, o_valid, o_busy, exp_addr);
            end
            n_checks++;
            if (o_last !== (i == 15) || o_done !== 1'b0) begin
                n_errors++;
                $display("FAIL %s_last[%0d]: last=%b done=%b required last=%b done=0",
                         name, i, o_last, o_done, (i == 15));
            end
            if (wiggle) begin
                i_mode    = i_mode + 2'd1;
                i_up_down = ~i_up_down;
            end
            tick();
        end
        n_checks++;
        if (o_done !== 1'b1 || o_valid !== 1'b0 || o_last !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_done: done=%b valid=%b last=%b required done=1 valid=0 last=0",
                     name, o_done, o_valid, o_last);
        end
        i_step = 1'b0;
        tick();
        n_checks++;
        if (o_done !== 1'b0 || o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_done_width: done=%b valid=%b required done=0 valid=0",
                     name, o_done, o_valid);
        end
    endtask

    task automatic test_hold_abort();
        i_start   = 1'b1;
        i_mode    = 2'd0;
        i_up_down = 1'b1;
        tick();
        i_start = 1'b0;
        i_step  = 1'b1;
        repeat (5) tick();
        i_step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (o_address !== 4'd5 || o_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL hold[%0d]: addr=%h valid=%b required addr=5 valid=1",
                         i, o_address, o_valid);
            end
        end
        i_abort = 1'b1;
        i_step  = 1'b1;
        tick();
        i_abort = 1'b0;
        i_step  = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_last !== 1'b0) begin
            n_errors++;
            $display("FAIL abort: valid=%b busy=%b done=%b last=%b required all 0",
                     o_valid, o_busy, o_done, o_last);
        end
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n_checks++;
        if (o_valid !== 1'b1 || o_address !== 4'd0 || o_done !== 1'b0) begin
            n_errors++;
            $display("FAIL restart_after_abort: valid=%b addr=%h done=%b required 1/0/0",
                     o_valid, o_address, o_done);
        end
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_idle: valid=%b done=%b required 0/0", o_valid, o_done);
        end
    endtask

    task automatic test_back_to_back();
        i_start   = 1'b1;
        i_mode    = 2'd0;
        i_up_down = 1'b1;
        tick();
        i_start = 1'b0;
        i_step  = 1'b1;
        repeat (16) tick();
        n_checks++;
        if (o_done !== 1'b1 || o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_done: done=%b valid=%b required 1/0", o_done, o_valid);
        end
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n_checks++;
        if (o_valid !== 1'b1 || o_address !== 4'd0 || o_done !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_restart: valid=%b addr=%h done=%b required 1/0/0",
                     o_valid, o_address, o_done);
        end
        repeat (2) tick();
        n_checks++;
        if (o_address !== 4'd2 || o_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_progress: addr=%h valid=%b required 2/1", o_address, o_valid);
        end
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        i_step = 1'b0;
        n_checks++;
        if (o_address !== 4'd0 || o_valid !== 1'b0 || o_last !== 1'b0 ||
            o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_run: addr=%h valid=%b last=%b done=%b busy=%b required 0",
                     o_address, o_valid, o_last, o_done, o_busy);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        i_start   = 1'b0;
        i_up_down = 1'b1;
        i_mode    = 2'd0;
        i_step    = 1'b0;
        i_abort   = 1'b0;
        test_reset();
        test_sweep("linear_up",   2'd0, 1'b1, 64'h0123456789ABCDEF, 1'b0);
        test_sweep("rowfast_up",  2'd1, 1'b1, 64'h048C159D26AE37BF, 1'b0);
        test_sweep("rowfast_dn",  2'd1, 1'b0, 64'hFB73EA62D951C840, 1'b0);
        test_sweep("gray_dn",     2'd2, 1'b0, 64'h89BAEFDC45762310, 1'b0);
        test_sweep("compl_up",    2'd3, 1'b1, 64'h0F1E2D3C4B5A6978, 1'b1);
        test_hold_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bist_addr_seq.md
# bist_addr_seq

Parametrised BIST address sequencer generating one full-coverage memory address sweep per start request. It supports four address orderings (linear, row-fast, Gray, address-complement), ascending or descending direction, and a step handshake. A March-element controller issues `start` once per element and `step` once per completed read/write. It drives the memory-under-test address bus and reports `last` and `done` so the controller can close the element.

## Interface
Parameters:
- `A_ROW`, default 2: row-field width; must be ≥1.
- `A_COL`, default 2: column-field width; must be ≥1.
- `A_W` (localparam) = `A_ROW + A_COL`: address width. Address layout is `{row, col}`, with col in the LSBs.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high; clock `clk`.
- `start` in 1: begin a sweep; honoured only when not busy.
- `up_down` in 1: 1 = ascending, 0 = descending; latched on an accepted start.
- `mode` in 2: ordering, latched on an accepted start; 0 linear, 1 row-fast, 2 Gray, 3 address-complement.
- `step` in 1: advance to the next element; honoured only while `valid`.
- `abort` in 1: terminate the current sweep without `done`.
- `address` out `A_W`: current memory address.
- `valid` out 1: `address` is a live sweep element.
- `last` out 1: `valid` and the current element is the final one of the sweep.
- `done` out 1: one-cycle pulse after the final element is stepped.
- `busy` out 1: equals `valid`; a sweep is in progress.

## Operation
- Internal state:
  - index counter `idx` (`A_W` bits, unsigned);
  - latched `mode_q` and `dir_q`;
  - FSM with states IDLE and RUN;
  - `done` register.
- Address mapping, a combinational function of registered `idx` and `mode_q` only (no path from any input to `address`):
  - mode 0: `address = idx`.
  - mode 1: row field = `idx[A_ROW-1:0]`, col field = `idx[A_W-1:A_ROW]`, so the row varies fastest.
  - mode 2: `address = idx ^ (idx >> 1)` (binary-reflected Gray).
  - mode 3: `k = idx >> 1`; `address = idx[0] ? ~k : k`, truncated to `A_W` bits. Yields 0, max, 1, max-1, …
  - Every mode is a bijection over 0..2^A_W−1. Each address appears exactly once per sweep.
- Direction:
  - Ascending: `idx` runs 0 → 2^A_W−1.
  - Descending: `idx` runs 2^A_W−1 → 0.
  - A descending sweep is the exact reverse of the ascending sequence for the same mode.
- IDLE:
  - `start=1` → RUN; `idx` ← 0 if `up_down` else all-ones; `mode_q` ← `mode`; `dir_q` ← `up_down`.
  - `step` and `abort` are ignored.
- RUN:
  - `step=1` with `idx` not terminal → `idx` ± 1 per `dir_q`.
  - `step=1` with `idx` terminal (all-ones ascending, 0 descending) → IDLE; `done` ← 1; `idx` holds.
  - `step=0` → hold.
  - `start` is ignored.
- Priority: `reset` > `abort` > `step` > `start`.
  - `abort` in RUN → IDLE next edge; `done` stays 0; `idx` holds.
- `last` = RUN && `idx` terminal for `dir_q`. It is purely a function of state and `idx`, independent of `step`.
- No wrap-around: the counter never passes the terminal value. The sweep ends instead.

## Timing
- Reset values: `address` = 0, `valid` = 0, `busy` = 0, `last` = 0, `done` = 0; `idx` = 0, `mode_q` = 0, `dir_q` = 1, FSM = IDLE.
- `start` sampled at edge N → from edge N the outputs show `valid` = 1 and `address` = first element.
- `step` sampled at edge N while `valid` → the next address is visible from edge N. Throughput is 1 address/cycle with `step` held high.
- Final `step` at edge N → from edge N `valid` = 0, `last` = 0, `done` = 1, for exactly one cycle.
- Full sweep, `step` held high: `valid` lasts 2^A_W cycles, and `done` asserts 2^A_W cycles after the `start` edge.
- Back-to-back: `start` high during the `done` cycle is accepted. `valid` returns at the next edge, so there is exactly one idle cycle between sweeps.
- `abort` at edge N → `valid` = 0 from edge N; `done` never pulses for that sweep.
- `reset` mid-RUN → all outputs at their reset values from the next edge, regardless of `step`, `abort` or `start`.
- `mode` and `up_down` changes during RUN have no effect until the next accepted `start`.

## Test plan
(All scenarios use `A_ROW` = 2, `A_COL` = 2.)
- Reset; start with mode 0, up; `step` held high → `address` 0,1,…,15. `last` asserts only with 15; `done` pulses 1 cycle after it; `valid` lasts 16 cycles.
- Start with mode 1, up → 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15. Start with mode 1, down → the exact reverse.
- Start with mode 2, down → 8,9,11,10,14,15,13,12,4,5,7,6,2,3,1,0; `last` with 0.
- Start with mode 3, up → 0,15,1,14,2,13,3,12,4,11,5,10,6,9,7,8. Toggle `mode` mid-sweep → sequence unchanged.
- Mode 0, up: step to `address` 5, hold `step` low 3 cycles → `address` stays 5. Then `abort` together with `step` → `valid` = 0 next cycle, `done` never 1, and `start` is accepted the cycle after.
- `start` during the `done` pulse → new sweep begins with one idle cycle gap. Assert `reset` mid-sweep with `step` = 1 → `address`, `valid`, `last`, `done`, `busy` all 0 next cycle.
